// File: rtl/move_scheduler.sv
// Arbitrates SPI player commands (buffered in a small FIFO) and gravity ticks
// onto one registered valid/ready command channel for the game executioner.
module move_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       spi_data,
   input  logic             spi_data_valid,
   output logic             spi_clear,
   input  logic             game_tick,
   input  logic             exec_ready,
   output logic             cmd_valid,
   output logic [1:0]       cmd_move,
   output logic [2:0]       cmd_piece,
   output logic             cmd_is_gravity,
   output logic [LVL_W-1:0] fifo_level,
   output logic [7:0]       drop_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic {
      ST_IDLE,
      ST_WAIT_LOW
   } intake_state_t;

   intake_state_t    r_state;
   logic             r_spi_clear;
   logic [7:0]       r_drop_count;

   logic [4:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;

   logic             r_tick_d;
   logic             r_grav_pend;
   logic             r_last_grav;

   logic             r_cmd_valid;
   logic [1:0]       r_cmd_move;
   logic [2:0]       r_cmd_piece;
   logic             r_cmd_is_gravity;

   logic             w_full;
   logic             w_empty;
   logic             w_byte_valid;
   logic             w_push;
   logic             w_drop;
   logic [2:0]       w_piece_in;
   logic [4:0]       w_head;
   logic             w_tick_edge;
   logic             w_slot_free;
   logic             w_grant_grav;
   logic             w_pop;
   logic             w_unused_bits;

   assign w_unused_bits = ^spi_data[7:6];

   // Full/empty use start-of-cycle occupancy, so a same-cycle pop never frees room for a push.
   assign w_full       = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_empty      = (r_level == '0);
   assign w_byte_valid = (r_state == ST_IDLE) && spi_data_valid && spi_data[5];
   assign w_push       = w_byte_valid && !w_full;
   assign w_drop       = w_byte_valid && w_full;
   assign w_piece_in   = (spi_data[4:2] == 3'd7) ? 3'd0 : spi_data[4:2];
   assign w_head       = r_mem[r_rd_ptr];

   assign w_tick_edge  = game_tick && !r_tick_d;
   assign w_slot_free  = !r_cmd_valid || exec_ready;
   assign w_grant_grav = w_slot_free && r_grav_pend && (w_empty || !r_last_grav);
   assign w_pop        = w_slot_free && !w_empty && !w_grant_grav;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_spi_clear  <= 1'b0;
         r_drop_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (spi_data_valid) begin
                  r_spi_clear <= 1'b1;
                  r_state     <= ST_WAIT_LOW;
                  if (w_drop && (r_drop_count != 8'hFF))
                     r_drop_count <= r_drop_count + 8'd1;
               end
            end
            ST_WAIT_LOW: begin
               r_spi_clear <= 1'b0;
               if (!spi_data_valid)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= {spi_data[1:0], w_piece_in};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // A fresh tick edge in the grant cycle re-arms gravity: set beats clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tick_d    <= 1'b0;
         r_grav_pend <= 1'b0;
      end else begin
         r_tick_d <= game_tick;
         if (w_tick_edge)
            r_grav_pend <= 1'b1;
         else if (w_grant_grav)
            r_grav_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cmd_valid      <= 1'b0;
         r_cmd_move       <= '0;
         r_cmd_piece      <= '0;
         r_cmd_is_gravity <= 1'b0;
         r_last_grav      <= 1'b0;
      end else if (w_grant_grav) begin
         r_cmd_valid      <= 1'b1;
         r_cmd_move       <= '0;
         r_cmd_piece      <= '0;
         r_cmd_is_gravity <= 1'b1;
         r_last_grav      <= 1'b1;
      end else if (w_pop) begin
         r_cmd_valid      <= 1'b1;
         r_cmd_move       <= w_head[4:3];
         r_cmd_piece      <= w_head[2:0];
         r_cmd_is_gravity <= 1'b0;
         r_last_grav      <= 1'b0;
      end else if (w_slot_free) begin
         r_cmd_valid      <= 1'b0;
      end
   end

   assign spi_clear      = r_spi_clear;
   assign drop_count     = r_drop_count;
   assign fifo_level     = r_level;
   assign cmd_valid      = r_cmd_valid;
   assign cmd_move       = r_cmd_move;
   assign cmd_piece      = r_cmd_piece;
   assign cmd_is_gravity = r_cmd_is_gravity;

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Sequences player commands and gravity ticks into the Tetris game executioner. Accepts command bytes from the SPI receiver, acknowledges and buffers them in a small FIFO, detects gravity ticks, and arbitrates both sources onto a single valid/ready command channel. It sits between `spi` and `game_executioner`, replacing the ad hoc `spi_data_valid` / `move_clk` stalling chain with one clocked handshake.

## Interface
- `FIFO_DEPTH`, 4, command FIFO entries; power of two, 2 to 16.
- `LVL_W`, `$clog2(FIFO_DEPTH+1)`, width of `fifo_level`.
- `clk` input 1, single clock (LSOSC domain); all logic on its rising edge.
- `reset_n` input 1, reset, asynchronous and active-low.
- `spi_data` input 8, SPI byte: [1:0] move, [4:2] piece select, [5] move_valid, [7:6] ignored.
- `spi_data_valid` input 1, level; held by SPI until cleared.
- `spi_clear` output 1, one-cycle acknowledge pulse to SPI `clear`.
- `game_tick` input 1, already-synchronized gravity clock; each rising edge is one gravity request.
- `exec_ready` input 1, executioner accepts a command this cycle.
- `cmd_valid` output 1, command present.
- `cmd_move` output 2, `command_t` encoding; 0 for gravity.
- `cmd_piece` output 3, piece select 0–6; raw value 7 forwarded as 0; 0 for gravity.
- `cmd_is_gravity` output 1, command is a gravity step.
- `fifo_level` output LVL_W, FIFO occupancy.
- `drop_count` output 8, saturating count of valid bytes dropped because the FIFO was full.

## Operation
- The SPI intake FSM has two states, IDLE and WAIT_LOW.
  - In IDLE with `spi_data_valid`=1: if bit5=1 and the FIFO is not full, push {move, piece}. If bit5=1 and the FIFO is full, `drop_count`++ (saturates at 255). If bit5=0, discard silently. In every case set `spi_clear`<=1 and go to WAIT_LOW.
  - In WAIT_LOW: `spi_clear`<=0. Stay until `spi_data_valid`=0, then go to IDLE. One byte is accepted per valid assertion.
- Full check uses the occupancy at the start of the cycle. A push while full is dropped even if a pop happens the same cycle.
- Gravity detection:
  - `tick_d` registers `game_tick`.
  - `game_tick & ~tick_d` sets `grav_pend`.
  - Further edges while `grav_pend`=1 are coalesced; only one step is issued.
- Output slot:
  - The slot is a registered {valid, move, piece, is_gravity}.
  - The slot is free when `cmd_valid`=0 or (`cmd_valid` & `exec_ready`).
  - While `cmd_valid`=1 and `exec_ready`=0, all outputs hold stable.
- Arbitration, evaluated only when the slot is free, is round-robin on `last_grav`:
  - Only `grav_pend`: grant gravity, clear `grav_pend`, `last_grav`<=1.
  - Only FIFO non-empty: pop to the slot, `last_grav`<=0.
  - Both pending: grant gravity if `last_grav`=0, else pop the FIFO.
  - Neither pending and slot accepted: `cmd_valid`<=0.
- A tick edge detected in the same cycle that gravity is granted sets `grav_pend` again. Set wins over clear.

## Timing
- Reset (async, `reset_n`=0) forces:
  - `spi_clear`, `cmd_valid`, `cmd_move`, `cmd_piece`, `cmd_is_gravity`, `fifo_level`, `drop_count` = 0.
  - FSM = IDLE, `grav_pend`=0, `tick_d`=0, `last_grav`=0, FIFO pointers = 0.
- Reset mid-operation: the FIFO is flushed, any pending command is lost, and no `spi_clear` is issued for the interrupted byte. On release in IDLE with `spi_data_valid` still high, the byte is accepted normally.
- Byte path, with edge E0 being the first edge sampling `spi_data_valid`=1:
  - `spi_clear`=1 and `fifo_level`+1 during E0–E1.
  - `cmd_valid`=1 after E1 if the slot is free and gravity does not win.
- Gravity path, with edge E0 being the first edge sampling `game_tick`=1 after 0: `grav_pend`=1 after E0; `cmd_valid`/`cmd_is_gravity`=1 after E1.
- Throughput is one command per cycle with `exec_ready` held high: accept and reload happen at the same edge.
- `fifo_level` pointer wrap is modulo FIFO_DEPTH; `fifo_level` ranges 0..FIFO_DEPTH.

## Test plan
- Reset, then byte 0x25 (valid, piece 1, move 1), `exec_ready`=1 → one `spi_clear` pulse; `cmd_valid` for one cycle with `cmd_move`=1, `cmd_piece`=1, `cmd_is_gravity`=0; `fifo_level` returns to 0.
- Byte 0x1F (bit5=0) → `spi_clear` pulses once; no push, no command, `drop_count`=0.
- `exec_ready`=0, send 6 valid bytes → `fifo_level`=4, `drop_count`=1 (one byte in the slot, one dropped). Raise `exec_ready` → 5 commands in order, then `cmd_valid`=0.
- `game_tick` rising edge while the FIFO holds 2 commands, `exec_ready`=1 → grants alternate G, M, M. Verify `cmd_move`/`cmd_piece`=0 on the gravity command.
- `exec_ready`=0 with a command held; 3 `game_tick` edges → exactly one gravity command is issued after release, and the held outputs stay unchanged while stalled.
- Assert `reset_n`=0 while `cmd_valid`=1 and `fifo_level`=3 → all outputs 0 immediately (asynchronous), nothing issued after release.
